sort_epoch_ctrl: RTL and testbench

SORT_EPOCH_CTRL -- requirements
Module: sort_epoch_ctrl

---
 rtl/sort_epoch_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_sort_epoch_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_epoch_ctrl.sv
// Epoch controller for a unary (race-logic) sorter: drives per-line fall times,
// timestamps each sorted output as it first goes low, then streams the results.
module sort_epoch_ctrl #(
  parameter int N      = 32,
  parameter int TW     = 4,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [$clog2(N)-1:0]   cfg_idx,
  input  logic [TW-1:0]          cfg_time,
  input  logic                   start,
  output logic                   busy,
  output logic [N-1:0]           sorter_in,
  input  logic [N-1:0]           sorter_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [$clog2(N)-1:0]   res_idx,
  output logic [TW+1:0]          res_time,
  output logic                   res_last,
  output logic                   order_err
);

  localparam int IW = $clog2(N);
  localparam logic [TW+1:0] T_ONE         = (TW+2)'(1);
  localparam logic [TW+1:0] T_RUN_LAST    = (TW+2)'(2**TW - 1);
  localparam logic [TW+1:0] T_SETTLE_LAST = (TW+2)'(2**TW + SETTLE - 1);
  localparam logic [TW+1:0] T_NONE        = '1;
  localparam logic [IW-1:0] IDX_ONE       = IW'(1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [TW+1:0]       r_t;
  logic [TW+1:0]       w_t_next;
  logic [N-1:0]        r_sorter_in;
  logic [N-1:0]        w_sorter_in_next;
  logic [IW-1:0]       r_res_idx;
  logic                r_order_err;

  logic                w_cfg_wr;
  logic                w_start;
  logic                w_sampling;
  logic                w_res_fire;
  logic                w_last_fire;
  logic [N-1:0]        w_lane_low;
  logic [N-1:0]        w_capd;
  logic [N-1:0][TW+1:0] w_cap_all;
  logic [N-2:0]        w_ooo;

  assign w_cfg_wr    = cfg_valid && (r_state == S_IDLE);
  assign w_start     = start && (r_state == S_IDLE);
  assign w_sampling  = (r_state == S_RUN) || (r_state == S_SETTLE);
  assign w_res_fire  = (r_state == S_DRAIN) && res_ready;
  assign w_last_fire = w_res_fire && (r_res_idx == IDX_LAST);

  // sorter_in is registered, so it is computed for the tick of the coming cycle
  assign w_t_next = (r_state == S_IDLE) ? '0 : (r_t + T_ONE);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start)                 w_state_next = S_RUN;
      S_RUN:    if (r_t == T_RUN_LAST)     w_state_next = S_SETTLE;
      S_SETTLE: if (r_t == T_SETTLE_LAST)  w_state_next = S_DRAIN;
      S_DRAIN:  if (w_last_fire)           w_state_next = S_IDLE;
      default:                             w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    res_last  = 1'b0;
    res_time  = '0;
    case (r_state)
      S_IDLE: cfg_ready = 1'b1;
      S_RUN, S_SETTLE: busy = 1'b1;
      S_DRAIN: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        res_last  = (r_res_idx == IDX_LAST);
        res_time  = w_capd[r_res_idx] ? w_cap_all[r_res_idx] : T_NONE;
      end
      default: cfg_ready = 1'b0;
    endcase
  end

  // ---------------- tick counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t <= '0;
    end else if (w_start) begin
      r_t <= '0;
    end else if (w_sampling) begin
      r_t <= r_t + T_ONE;
    end
  end

  // ---------------- per-line arm/time/capture ----------------
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_line
      logic          w_hit;
      logic [TW-1:0] w_time_eff;
      logic [TW-1:0] r_time;
      logic          r_armed;
      logic [TW+1:0] r_cap;
      logic          r_capd;

      // a write in the start cycle must already shape the first RUN tick
      assign w_hit          = w_cfg_wr && (cfg_idx == IW'(gi));
      assign w_time_eff     = w_hit ? cfg_time : r_time;
      assign w_lane_low[gi] = (r_armed || w_hit) && ({2'b00, w_time_eff} <= w_t_next);
      assign w_capd[gi]     = r_capd;
      assign w_cap_all[gi]  = r_cap;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_time  <= '0;
          r_armed <= 1'b0;
          r_cap   <= '0;
          r_capd  <= 1'b0;
        end else begin
          if (w_hit) begin
            r_time  <= cfg_time;
            r_armed <= 1'b1;
          end
          if (w_last_fire) begin
            r_armed <= 1'b0;
            r_cap   <= '0;
            r_capd  <= 1'b0;
          end else if (w_sampling && !r_capd && !sorter_out[gi]) begin
            r_cap  <= r_t;
            r_capd <= 1'b1;
          end
        end
      end
    end

    for (genvar gi = 0; gi < N - 1; gi++) begin : g_order
      assign w_ooo[gi] = sorter_out[gi] && !sorter_out[gi+1];
    end
  endgenerate

  // ---------------- sorter drive ----------------
  always_comb begin
    w_sorter_in_next = '1;
    case (w_state_next)
      S_RUN, S_SETTLE: w_sorter_in_next = ~w_lane_low;
      S_DRAIN:         w_sorter_in_next = r_sorter_in;
      default:         w_sorter_in_next = '1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sorter_in <= '1;
    end else begin
      r_sorter_in <= w_sorter_in_next;
    end
  end

  assign sorter_in = r_sorter_in;

  // ---------------- result index ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_idx <= '0;
    end else if (w_start) begin
      r_res_idx <= '0;
    end else if (w_res_fire) begin
      r_res_idx <= r_res_idx + IDX_ONE;
    end
  end

  assign res_idx = r_res_idx;

  // ---------------- sticky ordering check ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_order_err <= 1'b0;
    end else if (w_start) begin
      r_order_err <= 1'b0;
    end else if (w_sampling && (|w_ooo)) begin
      r_order_err <= 1'b1;
    end
  end

  assign order_err = r_order_err;

endmodule

// File: tb/tb_sort_epoch_ctrl.sv
// Scoreboard bench for sort_epoch_ctrl: directed epochs push expected result beats,
// a monitor pops and compares every accepted beat.
module tb_sort_epoch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [4:0]  cfg_idx;
  logic [3:0]  cfg_time;
  logic        start;
  logic        busy;
  logic [31:0] sorter_in;
  logic [31:0] sorter_out;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_idx;
  logic [5:0]  res_time;
  logic        res_last;
  logic        order_err;

  sort_epoch_ctrl #(.N(32), .TW(4), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_time(cfg_time),
    .start(start), .busy(busy),
    .sorter_in(sorter_in), .sorter_out(sorter_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
    .res_time(res_time), .res_last(res_last), .order_err(order_err)
  );

  always #5 clk = ~clk;

  // sorter model: ideal zero-delay (zeros gathered at low lines) or pass-through
  bit          passthru = 1'b0;
  int          zc;
  logic [63:0] low_mask;
  always_comb begin
    zc = 0;
    for (int i = 0; i < 32; i++) if (sorter_in[i] == 1'b0) zc++;
    low_mask   = (64'd1 << zc) - 64'd1;
    sorter_out = passthru ? sorter_in : ~low_mask[31:0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {int idx; int tm; bit last;} beat_t;
  beat_t sb_q[$];
  beat_t mon_e;
  int    exp_t[32];

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", {59'd0, res_idx}, 64'd99);
      end else begin
        mon_e = sb_q.pop_front();
        chk("res_idx", {59'd0, res_idx}, mon_e.idx);
        chk("res_time", {58'd0, res_time}, mon_e.tm);
        chk("res_last", {63'd0, res_last}, {63'd0, mon_e.last});
        $display("[TB] beat idx=%0d time=%0d last=%0d", res_idx, res_time, res_last);
      end
    end
  end

  task automatic exp_clear();
    for (int i = 0; i < 32; i++) exp_t[i] = 63;
  endtask

  task automatic push_all();
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.idx = i; b.tm = exp_t[i]; b.last = (i == 31);
      sb_q.push_back(b);
    end
  endtask

  // all stimulus tasks are entered and left 1 time unit after a rising edge
  task automatic cfg_write(input int idx, input int tm);
    cfg_valid = 1'b1; cfg_idx = 5'(idx); cfg_time = 4'(tm);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  int t_start;
  task automatic do_start(input bit with_wr, input int idx, input int tm);
    t_start = cyc;
    start = 1'b1;
    if (with_wr) begin cfg_valid = 1'b1; cfg_idx = 5'(idx); cfg_time = 4'(tm); end
    @(posedge clk); #1;
    start = 1'b0; cfg_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int exp_lat);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    chk({nm, "_valid_seen"}, {63'd0, res_valid}, 64'd1);
    if (exp_lat > 0) chk({nm, "_latency"}, 64'(cyc - t_start), 64'(exp_lat));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin @(negedge clk); n++; end
    chk({nm, "_idle"}, {63'd0, busy}, 64'd0);
    chk({nm, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    chk({nm, "_no_valid"}, {63'd0, res_valid}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_idx = '0; cfg_time = '0;
    start = 1'b0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset asserted mid-cycle, outputs must respond without an edge
    #3 rst_n = 1'b0;
    #1;
    chk("rst_sorter_in", {32'd0, sorter_in}, 64'hFFFF_FFFF);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_idx", {59'd0, res_idx}, 64'd0);
    chk("rst_res_time", {58'd0, res_time}, 64'd0);
    chk("rst_order_err", {63'd0, order_err}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    $display("[TB] reset checks done");

    // basic epoch: 12=3, 18=5, 0=1
    cfg_write(12, 3); cfg_write(18, 5); cfg_write(0, 1);
    exp_clear(); exp_t[0] = 1; exp_t[1] = 3; exp_t[2] = 5; push_all();
    do_start(1'b0, 0, 0);
    @(negedge clk);
    chk("basic_busy_run", {63'd0, busy}, 64'd1);
    chk("basic_cfg_ready_run", {63'd0, cfg_ready}, 64'd0);
    wait_valid("basic", 19);
    wait_idle("basic");
    chk("basic_order_err", {63'd0, order_err}, 64'd0);
    chk("basic_sorter_in_idle", {32'd0, sorter_in}, 64'hFFFF_FFFF);

    // all lines time 0, final write in the same cycle as start
    for (int i = 0; i < 31; i++) cfg_write(i, 0);
    exp_clear(); for (int i = 0; i < 32; i++) exp_t[i] = 0; push_all();
    do_start(1'b1, 31, 0);
    @(negedge clk);
    chk("all0_sorter_in_first_run", {32'd0, sorter_in}, 64'd0);
    wait_valid("all0", 19);
    wait_idle("all0");

    // backpressure at idx4 (idx4 time 15 = last RUN tick)
    cfg_write(7, 2); cfg_write(9, 4); cfg_write(1, 6); cfg_write(30, 9); cfg_write(2, 15);
    cfg_write(2, 15);
    exp_clear(); exp_t[0] = 2; exp_t[1] = 4; exp_t[2] = 6; exp_t[3] = 9; exp_t[4] = 15; push_all();
    do_start(1'b0, 0, 0);
    wait_valid("bp", 19);
    begin
      int n = 0;
      while (res_idx != 5'd3 && n < 50) begin @(negedge clk); n++; end
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_idx", {59'd0, res_idx}, 64'd4);
      chk("bp_hold_time", {58'd0, res_time}, 64'd15);
      chk("bp_hold_valid", {63'd0, res_valid}, 64'd1);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle("bp");

    // pass-through sorter: line5 falls alone -> out of order
    passthru = 1'b1;
    cfg_write(5, 2);
    exp_clear(); exp_t[5] = 2; push_all();
    do_start(1'b0, 0, 0);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("pt_in_settle", {63'd0, busy && !res_valid}, 64'd1);
    chk("pt_order_err_settle", {63'd0, order_err}, 64'd1);
    wait_valid("pt", 0);
    wait_idle("pt");
    chk("pt_order_err_held", {63'd0, order_err}, 64'd1);

    // ideal sorter again: order_err clears on accepted start
    passthru = 1'b0;
    cfg_write(20, 7);
    exp_clear(); exp_t[0] = 7; push_all();
    do_start(1'b0, 0, 0);
    @(negedge clk);
    chk("clr_order_err", {63'd0, order_err}, 64'd0);
    wait_valid("clr", 19);
    wait_idle("clr");
    chk("clr_order_err_end", {63'd0, order_err}, 64'd0);

    // abort at T=7 of RUN, then a fresh epoch must not see stale lines
    cfg_write(10, 1); cfg_write(25, 12);
    do_start(1'b0, 0, 0);
    repeat (7) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    chk("abort_sorter_in", {32'd0, sorter_in}, 64'hFFFF_FFFF);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_res_valid", {63'd0, res_valid}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    cfg_write(3, 0);
    exp_clear(); exp_t[0] = 0; push_all();
    do_start(1'b0, 0, 0);
    wait_valid("post_abort", 19);
    wait_idle("post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
